// File: rtl/uart_tx_queue.sv
// uart_tx_queue: 16-byte FIFO between the monitor FSM and the osdvu uart core.
// Ports: CLK, rst (sync, active-high); push side in_valid/in_data/in_ready;
// uart side u_is_transmitting/u_transmit/u_tx_byte; status count, busy.
// Optional: define UART_TX_QUEUE_HEX_EN to send each byte as two ASCII hex chars.
module uart_tx_queue #(
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int GUARD_CYCLES    = 2
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  input  logic                     u_is_transmitting,
  output logic                     u_transmit,
  output logic [7:0]               u_tx_byte,
  output logic [FIFO_ADDR_WIDTH:0] count,
  output logic                     busy
);

  localparam int AW    = FIFO_ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;

  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [3:0]    G_INIT  = 4'(GUARD_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    GUARD,
    WAIT
`ifdef UART_TX_QUEUE_HEX_EN
    ,
    SEND_LO,
    GUARD_LO,
    WAIT_LO
`endif
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    pop_byte;
  logic [3:0]    guard_cnt;

  logic push;
  logic pop;
  logic send_hi;
  logic send_lo;
  logic guard_tick;

`ifdef UART_TX_QUEUE_HEX_EN
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction
`endif

  assign in_ready = (count != FULL);
  assign push     = in_valid & in_ready;
  assign busy     = (count != '0) || (state != IDLE);

  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    send_hi    = 1'b0;
    send_lo    = 1'b0;
    guard_tick = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0 && !u_is_transmitting) begin
          pop       = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        send_hi   = 1'b1;
        state_nxt = GUARD;
      end
      // Busy flag lags the start pulse, so it is not trusted here.
      GUARD: begin
        guard_tick = 1'b1;
        if (guard_cnt <= 4'd1) state_nxt = WAIT;
      end
      WAIT: begin
`ifdef UART_TX_QUEUE_HEX_EN
        if (!u_is_transmitting) state_nxt = SEND_LO;
`else
        if (!u_is_transmitting) state_nxt = IDLE;
`endif
      end
`ifdef UART_TX_QUEUE_HEX_EN
      SEND_LO: begin
        send_lo   = 1'b1;
        state_nxt = GUARD_LO;
      end
      GUARD_LO: begin
        guard_tick = 1'b1;
        if (guard_cnt <= 4'd1) state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        if (!u_is_transmitting) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      pop_byte   <= 8'h00;
      guard_cnt  <= 4'd0;
      u_transmit <= 1'b0;
      u_tx_byte  <= 8'h00;
    end else begin
      state      <= state_nxt;
      u_transmit <= send_hi | send_lo;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        pop_byte <= mem[rd_ptr];
      end
      // Push and pop together leave count unchanged.
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
      if (send_hi || send_lo) begin
        guard_cnt <= G_INIT;
`ifdef UART_TX_QUEUE_HEX_EN
        u_tx_byte <= send_hi ? hex_char(pop_byte[7:4])
                             : hex_char(pop_byte[3:0]);
`else
        u_tx_byte <= pop_byte;
`endif
      end else if (guard_tick && guard_cnt != 4'd0) begin
        guard_cnt <= guard_cnt - 4'd1;
      end
    end
  end

endmodule
